// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter
// Shares one flash read port between the audio sample path (aud_*) and an
// auxiliary path (aux_*). Each side has a pending flag and address register;
// the FSM (IDLE -> ISSUE -> WAIT_DATA -> RESPOND) arbitrates in IDLE with
// round-robin on ties, runs the flash read handshake, captures the word into
// the granted side's data register, and pulses that side's done.
//
// Ports:
//   CLK_50M, reset            clock, asynchronous active-high reset
//   aud_req/aud_addr          audio request pulse and address
//   aud_done/aud_data         audio completion pulse and last returned word
//   aux_req/aux_addr          auxiliary request pulse and address
//   aux_done/aux_data         auxiliary completion pulse and last returned word
//   aud_overrun               sticky: audio request while audio still pending
//   timeout_err               sticky: a read was aborted by timeout
//   flash_mem_*               flash read interface (read/waitrequest/readdatavalid)
//
// Optional feature: define FLASH_TIMEOUT_EN to abort reads whose readdatavalid
// does not arrive within TIMEOUT_CYCLES cycles of entering WAIT_DATA.
module flash_read_arbiter #(
    parameter int unsigned ADDR_W         = 23,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic              aud_req,
    input  logic [ADDR_W-1:0] aud_addr,
    output logic              aud_done,
    output logic [DATA_W-1:0] aud_data,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_done,
    output logic [DATA_W-1:0] aux_data,
    output logic              aud_overrun,
    output logic              timeout_err,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              flash_mem_readdatavalid
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitData, StRespond} state_e;

    state_e            state_q, state_d;
    logic              aud_pend_q, aux_pend_q;
    logic [ADDR_W-1:0] aud_addr_q, aux_addr_q;
    logic              grant_aux_q;   // current/last grant; reset to aux so audio wins first tie
    logic              aud_want, aux_want, pick_aux, start;
    logic [ADDR_W-1:0] aud_next_addr, aux_next_addr;
    logic              timeout_hit, capture;
    logic [DATA_W-1:0] cap_word;

    assign flash_mem_byteenable = 4'b1111;

    // A request arriving this cycle is already eligible, so IDLE -> ISSUE
    // happens one cycle after the request pulse.
    assign aud_want      = aud_pend_q | aud_req;
    assign aux_want      = aux_pend_q | aux_req;
    assign aud_next_addr = aud_req ? aud_addr : aud_addr_q;
    assign aux_next_addr = aux_req ? aux_addr : aux_addr_q;
    assign pick_aux      = aux_want & (~aud_want | ~grant_aux_q);
    assign start         = (state_q == StIdle) & (aud_want | aux_want);

    // Valid in the same cycle as the timeout wins: cap_word prefers readdata.
    assign capture  = (state_q == StWaitData) & (flash_mem_readdatavalid | timeout_hit);
    assign cap_word = flash_mem_readdatavalid ? flash_mem_readdata : '0;

`ifdef FLASH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] to_cnt_q;
    logic            timeout_err_q;

    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // Cleared while in ISSUE, so it reads 0 on the first WAIT_DATA cycle.
            if (state_q == StIssue) begin
                to_cnt_q <= '0;
            end else if (state_q == StWaitData) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_hit = (state_q == StWaitData) & ~flash_mem_readdatavalid &
                         (to_cnt_q == TimeoutVal);
    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StIssue;
            StIssue:    if (!flash_mem_waitrequest) state_d = StWaitData;
            StWaitData: if (capture) state_d = StRespond;
            StRespond:  state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        flash_mem_read = 1'b0;
        aud_done       = 1'b0;
        aux_done       = 1'b0;
        unique case (state_q)
            StIssue:   flash_mem_read = 1'b1;
            StRespond: begin
                aud_done = ~grant_aux_q;
                aux_done = grant_aux_q;
            end
            default: ;
        endcase
    end

    // Request bookkeeping, grant/address latch, data capture
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            aud_pend_q        <= 1'b0;
            aux_pend_q        <= 1'b0;
            aud_addr_q        <= '0;
            aux_addr_q        <= '0;
            aud_overrun       <= 1'b0;
            grant_aux_q       <= 1'b1;
            flash_mem_address <= '0;
            aud_data          <= '0;
            aux_data          <= '0;
        end else begin
            // A new request in the done cycle keeps the flag set.
            if (aud_req) begin
                aud_pend_q <= 1'b1;
                aud_addr_q <= aud_addr;
            end else if (aud_done) begin
                aud_pend_q <= 1'b0;
            end
            if (aux_req) begin
                aux_pend_q <= 1'b1;
                aux_addr_q <= aux_addr;
            end else if (aux_done) begin
                aux_pend_q <= 1'b0;
            end
            if (aud_req && aud_pend_q && !aud_done) begin
                aud_overrun <= 1'b1;
            end
            if (start) begin
                grant_aux_q       <= pick_aux;
                flash_mem_address <= pick_aux ? aux_next_addr : aud_next_addr;
            end
            if (capture) begin
                if (grant_aux_q) begin
                    aux_data <= cap_word;
                end else begin
                    aud_data <= cap_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
module tb_flash_read_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 255;

    logic          CLK_50M = 1'b0;
    logic          reset   = 1'b1;
    logic          aud_req = 1'b0, aux_req = 1'b0;
    logic [AW-1:0] aud_addr = '0, aux_addr = '0;
    logic          aud_done, aux_done, aud_overrun, timeout_err;
    logic [DW-1:0] aud_data, aux_data;
    logic          flash_mem_read;
    logic [AW-1:0] flash_mem_address;
    logic [3:0]    flash_mem_byteenable;
    logic          flash_mem_waitrequest   = 1'b0;
    logic [DW-1:0] flash_mem_readdata      = '0;
    logic          flash_mem_readdatavalid = 1'b0;

    flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK_50M                 (CLK_50M),
        .reset                   (reset),
        .aud_req                 (aud_req),
        .aud_addr                (aud_addr),
        .aud_done                (aud_done),
        .aud_data                (aud_data),
        .aux_req                 (aux_req),
        .aux_addr                (aux_addr),
        .aux_done                (aux_done),
        .aux_data                (aux_data),
        .aud_overrun             (aud_overrun),
        .timeout_err             (timeout_err),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid)
    );

    always #5 CLK_50M = ~CLK_50M;

    typedef struct {
        bit            is_aux;
        logic [DW-1:0] data;
        int            cyc;     // expected done cycle, -1 = not checked
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] rd_q[$];
    int            checks = 0, failures = 0;
    int            cyc = 0;
    int            rd_hi = 0;
    bit            auto_resp = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Flash contents seen by the responder.
    function automatic logic [DW-1:0] flash_word(input logic [AW-1:0] a);
        case (a)
            23'h000123: return 32'hDEADBEEF;
            23'h000200: return 32'h2000_0A0A;
            23'h000300: return 32'h3000_0B0B;
            23'h000400: return 32'h4000_0C0C;
            23'h000500: return 32'h5000_0D0D;
            23'h000600: return 32'h6000_0E0E;
            23'h000700: return 32'h7000_0F0F;
            23'h000010: return 32'h0010_1234;
            23'h000020: return 32'h0020_1234;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    initial forever begin
        @(posedge CLK_50M);
        cyc++;
    end

    // Flash responder: readdatavalid one cycle after the accepting cycle.
    initial forever begin
        logic [AW-1:0] a;
        @(negedge CLK_50M);
        if (auto_resp && flash_mem_read && !flash_mem_waitrequest) begin
            a = flash_mem_address;
            @(posedge CLK_50M);
            #1;
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = flash_word(a);
            @(posedge CLK_50M);
            #1;
            flash_mem_readdatavalid = 1'b0;
            flash_mem_readdata      = '0;
        end
    end

    // Monitor: completions against the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge CLK_50M);
        if (aud_done && aux_done) check("both_done", 1, 0);
        if (aud_done || aux_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {aux_done, aud_done}, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_who", aux_done, e.is_aux);
                check("done_data", aux_done ? aux_data : aud_data, e.data);
                if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Monitor: flash read strobes against expected addresses.
    initial forever begin
        @(negedge CLK_50M);
        if (flash_mem_read) begin
            rd_hi++;
            if (rd_q.size() == 0) begin
                check("unexpected_read", flash_mem_address, '1);
            end else begin
                check("read_addr", flash_mem_address, rd_q[0]);
                if (!flash_mem_waitrequest) void'(rd_q.pop_front());
            end
        end
    end

    task automatic pulse(input bit do_aud, input logic [AW-1:0] aa,
                         input bit do_aux, input logic [AW-1:0] xa, output int c0);
        @(posedge CLK_50M);
        #1;
        c0 = cyc;
        aud_req = do_aud; aud_addr = aa;
        aux_req = do_aux; aux_addr = xa;
        @(posedge CLK_50M);
        #1;
        aud_req = 1'b0;
        aux_req = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0) && n < budget) begin
            @(posedge CLK_50M);
            n++;
        end
        repeat (2) @(posedge CLK_50M);
        #1;
        check(name, exp_q.size() + rd_q.size(), 0);
        exp_q.delete();
        rd_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        // Reset state
        repeat (3) @(posedge CLK_50M);
        #1;
        check("rst_read", flash_mem_read, 0);
        check("rst_addr", flash_mem_address, 0);
        check("rst_aud_data", aud_data, 0);
        check("rst_aux_data", aux_data, 0);
        check("rst_done", {aud_done, aux_done}, 0);
        check("rst_flags", {aud_overrun, timeout_err}, 0);
        check("byteenable", flash_mem_byteenable, 4'b1111);
        reset = 1'b0;

        // First tie after reset: audio first, aux 4 cycles later
        pulse(1, 23'h200, 1, 23'h300, c0);
        rd_q.push_back(23'h200);
        rd_q.push_back(23'h300);
        exp_q.push_back('{1'b0, 32'h2000_0A0A, c0 + 3});
        exp_q.push_back('{1'b1, 32'h3000_0B0B, c0 + 7});
        drain("tie1_drain", 40);

        // Single audio read, best-case latency
        pulse(1, 23'h123, 0, '0, c0);
        rd_q.push_back(23'h123);
        exp_q.push_back('{1'b0, 32'hDEADBEEF, c0 + 3});
        drain("single_drain", 40);
        check("single_addr_held", flash_mem_address, 23'h123);
        check("aux_data_held", aux_data, 32'h3000_0B0B);

        // Second tie: audio granted last, so aux wins
        pulse(1, 23'h400, 1, 23'h500, c0);
        rd_q.push_back(23'h500);
        rd_q.push_back(23'h400);
        exp_q.push_back('{1'b1, 32'h5000_0D0D, c0 + 3});
        exp_q.push_back('{1'b0, 32'h4000_0C0C, c0 + 7});
        drain("tie2_drain", 40);

        // waitrequest stall of 5 cycles
        flash_mem_waitrequest = 1'b1;
        rd_hi = 0;
        rd_q.push_back(23'h600);
        pulse(1, 23'h600, 0, '0, c0);
        exp_q.push_back('{1'b0, 32'h6000_0E0E, c0 + 8});
        repeat (5) @(posedge CLK_50M);
        #1;
        flash_mem_waitrequest = 1'b0;
        drain("stall_drain", 40);
        check("stall_read_cycles", rd_hi, 6);

        // Audio overrun behind a stalled aux read
        flash_mem_waitrequest = 1'b1;
        rd_q.push_back(23'h700);
        pulse(0, '0, 1, 23'h700, c0);
        exp_q.push_back('{1'b1, 32'h7000_0F0F, -1});
        pulse(1, 23'h010, 0, '0, c0);
        check("overrun_first", aud_overrun, 0);
        pulse(1, 23'h020, 0, '0, c0);
        check("overrun_set", aud_overrun, 1);
        rd_q.push_back(23'h020);
        exp_q.push_back('{1'b0, 32'h0020_1234, -1});
        flash_mem_waitrequest = 1'b0;
        drain("overrun_drain", 40);
        check("overrun_sticky", aud_overrun, 1);
        check("overrun_data", aud_data, 32'h0020_1234);

        // Reset during WAIT_DATA, then a late readdatavalid
        auto_resp = 1'b0;
        rd_q.push_back(23'h0800);
        pulse(1, 23'h0800, 0, '0, c0);
        @(posedge CLK_50M);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_read", flash_mem_read, 0);
        check("midrst_addr", flash_mem_address, 0);
        check("midrst_data", {aud_data, aux_data}, 0);
        check("midrst_flags", {aud_overrun, timeout_err}, 0);
        @(posedge CLK_50M);
        #1;
        reset = 1'b0;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'hCAFE_F00D;
        @(posedge CLK_50M);
        #1;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = '0;
        repeat (4) @(posedge CLK_50M);
        #1;
        check("late_valid_data", aud_data, 0);
        check("late_valid_idle", {flash_mem_read, aud_done, aux_done}, 0);
        drain("midrst_drain", 4);

`ifdef FLASH_TIMEOUT_EN
        // No readdatavalid: done TO+1 cycles after WAIT_DATA entry (cycle c0+2)
        rd_q.push_back(23'h0900);
        pulse(1, 23'h0900, 0, '0, c0);
        exp_q.push_back('{1'b0, 32'h0, c0 + TO + 3});
        drain("timeout_drain", TO + 20);
        check("timeout_err", timeout_err, 1);
`else
        check("timeout_err_tied", timeout_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
